// File: rtl/spram_arb_if.sv
// Two-requester request/response bundle for the single-port RAM arbiter.
// Master drives the requests; slave returns Ready and one-cycle-latency read data.
interface spram_arb_if #(
  parameter int DW = 32,
  parameter int AW = 9
) ();
  logic          R0_Valid;
  logic          R0_Ready;
  logic          R0_We;
  logic [AW-1:0] R0_Addr;
  logic [DW-1:0] R0_Wdata;
  logic          R0_RspValid;
  logic [DW-1:0] R0_RspData;

  logic          R1_Valid;
  logic          R1_Ready;
  logic          R1_We;
  logic [AW-1:0] R1_Addr;
  logic [DW-1:0] R1_Wdata;
  logic          R1_RspValid;
  logic [DW-1:0] R1_RspData;

  modport master (
    output R0_Valid, R0_We, R0_Addr, R0_Wdata,
    output R1_Valid, R1_We, R1_Addr, R1_Wdata,
    input  R0_Ready, R0_RspValid, R0_RspData,
    input  R1_Ready, R1_RspValid, R1_RspData
  );

  modport slave (
    input  R0_Valid, R0_We, R0_Addr, R0_Wdata,
    input  R1_Valid, R1_We, R1_Addr, R1_Wdata,
    output R0_Ready, R0_RspValid, R0_RspData,
    output R1_Ready, R1_RspValid, R1_RspData
  );
endinterface

// File: rtl/spram_arb.sv
// Clears a single-port RAM after reset, then round-robin arbitrates two requesters onto it.
// Grant is combinational (Ready = grant); read response one cycle after transfer; no Ready until clear completes.
module spram_arb #(
  parameter int DW        = 32,
  parameter int AW        = 9,
  parameter int RAM_DEPTH = 1 << AW
) (
  input  logic          Clk,
  input  logic          Rst_n,
  output logic          Init_Done,
  spram_arb_if.slave    bus,
  output logic          Csb0,
  output logic          Web0,
  output logic [AW-1:0] ADDR0,
  output logic [DW-1:0] DIN0,
  input  logic [DW-1:0] DOUT0
);

  typedef enum logic [1:0] {BOOT, INIT, RUN} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          last_q, last_d;
  logic          rsp0_q, rsp0_d;
  logic          rsp1_q, rsp1_d;
  logic          gnt0, gnt1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      last_q  <= 1'b1;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      last_q  <= last_d;
      rsp0_q  <= rsp0_d;
      rsp1_q  <= rsp1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    last_d  = last_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    Csb0    = 1'b1;
    Web0    = 1'b1;
    ADDR0   = '0;
    DIN0    = '0;

    case (state_q)
      BOOT: begin
        state_d = INIT;
        cnt_d   = '0;
      end
      INIT: begin
        Csb0  = 1'b0;
        Web0  = 1'b0;
        ADDR0 = cnt_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      RUN: begin
        // On a tie the requester that did not win last time gets the slot.
        gnt0 = bus.R0_Valid & (~bus.R1_Valid | last_q);
        gnt1 = bus.R1_Valid & ~gnt0;
        if (gnt0) begin
          Csb0   = 1'b0;
          Web0   = ~bus.R0_We;
          ADDR0  = bus.R0_Addr;
          DIN0   = bus.R0_Wdata;
          last_d = 1'b0;
        end else if (gnt1) begin
          Csb0   = 1'b0;
          Web0   = ~bus.R1_We;
          ADDR0  = bus.R1_Addr;
          DIN0   = bus.R1_Wdata;
          last_d = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase

    rsp0_d = gnt0 & ~bus.R0_We;
    rsp1_d = gnt1 & ~bus.R1_We;
  end

  assign Init_Done       = done_q;
  assign bus.R0_Ready    = gnt0;
  assign bus.R1_Ready    = gnt1;
  assign bus.R0_RspValid = rsp0_q;
  assign bus.R1_RspValid = rsp1_q;
  assign bus.R0_RspData  = DOUT0;
  assign bus.R1_RspData  = DOUT0;

endmodule

// File: tb/tb_spram_arb.sv
// Directed bench for spram_arb (AW=4) with a cycle-level reference model and a behavioural RAM.
`timescale 1ns/1ps
module tb_spram_arb;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          Init_Done;
  logic          Csb0, Web0;
  logic [AW-1:0] ADDR0;
  logic [DW-1:0] DIN0;
  logic [DW-1:0] DOUT0 = '0;

  spram_arb_if #(.DW(DW), .AW(AW)) bus ();

  spram_arb #(.DW(DW), .AW(AW), .RAM_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Init_Done(Init_Done), .bus(bus),
    .Csb0(Csb0), .Web0(Web0), .ADDR0(ADDR0), .DIN0(DIN0), .DOUT0(DOUT0)
  );

  always #5 Clk = ~Clk;

  // Behavioural single-port RAM with registered read data; starts with non-zero junk.
  logic [DW-1:0] ram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = 32'hBAD0_0000 | i;
  always @(posedge Clk) begin
    if (!Csb0) begin
      if (!Web0) ram[ADDR0] <= DIN0;
      else       DOUT0 <= ram[ADDR0];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycles since reset release decide the phase.
  logic [DW-1:0] mdl_mem [DEPTH];
  int            k = 0;
  int            mlast = 1;
  bit            pend = 0;
  int            pwho = 0;
  logic [DW-1:0] pdat = '0;
  int            first_done = 0;
  int            gnt_log [$];
  logic [32:0]   rsp_log [$];

  always @(negedge Clk) begin
    int            g;
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            npend;
    int            nwho;
    logic [DW-1:0] ndat;
    if (!Rst_n) begin
      k = 0; mlast = 1; pend = 0; first_done = 0;
      chk("rst_csb", Csb0, 1);
      chk("rst_web", Web0, 1);
      chk("rst_done", Init_Done, 0);
      chk("rst_rv0", bus.R0_RspValid, 0);
      chk("rst_rv1", bus.R1_RspValid, 0);
      chk("rst_rdy0", bus.R0_Ready, 0);
      chk("rst_rdy1", bus.R1_Ready, 0);
    end else begin
      k++;
      chk("init_done", Init_Done, k >= 18);
      if (Init_Done && first_done == 0) first_done = k;
      chk("rv0", bus.R0_RspValid, pend && pwho == 0);
      chk("rv1", bus.R1_RspValid, pend && pwho == 1);
      if (pend) chk("rdata", (pwho == 0) ? bus.R0_RspData : bus.R1_RspData, pdat);
      if (bus.R0_RspValid) rsp_log.push_back({1'b0, bus.R0_RspData});
      if (bus.R1_RspValid) rsp_log.push_back({1'b1, bus.R1_RspData});
      npend = 0; nwho = 0; ndat = '0;
      if (k == 1) begin
        chk("boot_csb", Csb0, 1); chk("boot_web", Web0, 1);
        chk("boot_addr", ADDR0, 0); chk("boot_din", DIN0, 0);
        chk("boot_rdy", {bus.R1_Ready, bus.R0_Ready}, 0);
      end else if (k <= 17) begin
        chk("init_csb", Csb0, 0); chk("init_web", Web0, 0);
        chk("init_addr", ADDR0, k - 2); chk("init_din", DIN0, 0);
        chk("init_rdy", {bus.R1_Ready, bus.R0_Ready}, 0);
        mdl_mem[k-2] = '0;
      end else begin
        g = -1;
        if (bus.R0_Valid && bus.R1_Valid) g = (mlast == 1) ? 0 : 1;
        else if (bus.R0_Valid)            g = 0;
        else if (bus.R1_Valid)            g = 1;
        chk("rdy0", bus.R0_Ready, g == 0);
        chk("rdy1", bus.R1_Ready, g == 1);
        if (g >= 0) begin
          we = (g == 0) ? bus.R0_We    : bus.R1_We;
          a  = (g == 0) ? bus.R0_Addr  : bus.R1_Addr;
          d  = (g == 0) ? bus.R0_Wdata : bus.R1_Wdata;
          chk("run_csb", Csb0, 0); chk("run_web", Web0, !we);
          chk("run_addr", ADDR0, a); chk("run_din", DIN0, d);
          if (we) mdl_mem[a] = d;
          else begin npend = 1; nwho = g; ndat = mdl_mem[a]; end
          mlast = g;
          gnt_log.push_back(g);
        end else begin
          chk("idle_csb", Csb0, 1); chk("idle_web", Web0, 1);
          chk("idle_addr", ADDR0, 0); chk("idle_din", DIN0, 0);
        end
      end
      pend = npend; pwho = nwho; pdat = ndat;
    end
  end

  task automatic cyc();
    @(posedge Clk); #1;
  endtask

  task automatic req0(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.R0_Valid = v; bus.R0_We = we; bus.R0_Addr = a; bus.R0_Wdata = d;
  endtask

  task automatic req1(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.R1_Valid = v; bus.R1_We = we; bus.R1_Addr = a; bus.R1_Wdata = d;
  endtask

  initial begin
    Rst_n = 1'b0;
    req0(0, 0, 0, 0);
    req1(0, 0, 0, 0);
    repeat (3) cyc();
    Rst_n = 1'b1;
    // Valids during clear must be ignored.
    req0(1, 1, 4'd2, 32'h1234_5678);
    repeat (10) cyc();
    req0(0, 0, 0, 0);
    repeat (10) cyc();
    chk("init_done_cycle", first_done, 18);

    // Tie from reset: R0 wins first, then alternation.
    gnt_log.delete();
    req0(1, 1, 4'd3, 32'h11);
    req1(1, 1, 4'd7, 32'h22);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("tie_csb", Csb0, 0);
      @(posedge Clk); #1;
    end
    req0(0, 0, 0, 0);
    req1(0, 0, 0, 0);
    cyc();
    chk("tie_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
      chk("tie_g0", gnt_log[0], 0);
      chk("tie_g1", gnt_log[1], 1);
      chk("tie_g2", gnt_log[2], 0);
      chk("tie_g3", gnt_log[3], 1);
    end

    // Interleaved readers: responses back to back, each to its own requester.
    rsp_log.delete();
    req0(1, 0, 4'd3, 0); cyc();
    req0(0, 0, 0, 0); req1(1, 0, 4'd7, 0); cyc();
    req1(0, 0, 0, 0); cyc(); cyc();
    chk("ilv_count", rsp_log.size(), 2);
    if (rsp_log.size() == 2) begin
      chk("ilv_first", rsp_log[0], {1'b0, 32'h11});
      chk("ilv_second", rsp_log[1], {1'b1, 32'h22});
    end

    // Write then read the same address on consecutive cycles.
    rsp_log.delete();
    req0(1, 1, 4'd5, 32'hDEAD_BEEF); cyc();
    req0(1, 0, 4'd5, 0); cyc();
    req0(0, 0, 0, 0); cyc(); cyc();
    chk("rd_count", rsp_log.size(), 1);
    if (rsp_log.size() == 1) chk("rd_data", rsp_log[0], {1'b0, 32'hDEAD_BEEF});

    // Idle RUN.
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("idle10_csb", Csb0, 1);
      chk("idle10_web", Web0, 1);
      chk("idle10_addr", ADDR0, 0);
      chk("idle10_rdy", {bus.R1_Ready, bus.R0_Ready}, 0);
      @(posedge Clk); #1;
    end

    // Reset in the cycle after a read transfer drops the response and reruns the clear.
    rsp_log.delete();
    req0(1, 0, 4'd5, 0); cyc();
    req0(0, 0, 0, 0);
    Rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("mid_rst_csb", Csb0, 1);
      chk("mid_rst_rv0", bus.R0_RspValid, 0);
      @(posedge Clk); #1;
    end
    Rst_n = 1'b1;
    repeat (20) cyc();
    chk("mid_rst_drop", rsp_log.size(), 0);
    chk("reinit_done_cycle", first_done, 18);
    req0(1, 0, 4'd5, 0); cyc();
    req0(0, 0, 0, 0); cyc(); cyc();
    chk("reinit_count", rsp_log.size(), 1);
    if (rsp_log.size() == 1) chk("reinit_data", rsp_log[0], {1'b0, 32'h0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spram_arb.md
SPRAM_ARB -- requirements
Module: spram_arb

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data word width.
REQ-002 SHALL have parameter AW, default 9, meaning address width.
REQ-003 SHALL have parameter RAM_DEPTH, default 1<<AW, meaning number of words cleared at init.
REQ-004 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Init_Done  output  1  high once memory clear is complete.
REQ-007 SHALL have, for requester n in {0,1}, ports Rn_Valid (in, 1), Rn_Ready (out, 1), Rn_We (in, 1), Rn_Addr (in, AW), Rn_Wdata (in, DW): request channel.
REQ-008 SHALL have, for n in {0,1}, ports Rn_RspValid (out, 1) and Rn_RspData (out, DW): read response.
REQ-009 SHALL have RAM-side ports Csb0 (out, 1, active-low select), Web0 (out, 1, active-low write), ADDR0 (out, AW), DIN0 (out, DW) and DOUT0 (in, DW, registered read data valid the cycle after a read select).

Function
REQ-010 SHALL implement states BOOT, INIT and RUN in a registered state machine.
REQ-011 BOOT SHALL last exactly one cycle after reset release, then go to INIT.
REQ-012 In BOOT, Csb0=1, Web0=1, ADDR0=0, DIN0=0.
REQ-013 In INIT, each cycle SHALL drive Csb0=0, Web0=0, DIN0=0 and ADDR0=init counter; the counter SHALL start at 0 and increment by 1 per cycle.
REQ-014 The INIT write to address RAM_DEPTH-1 SHALL be the last; the next state SHALL be RUN, with Init_Done registered high from the first RUN cycle onward.
REQ-015 In BOOT and INIT, R0_Ready=R1_Ready=0, and incoming Valids SHALL be ignored.
REQ-016 In RUN, grant SHALL be combinational: only one Rn_Valid high means that n is granted; both high means the requester not granted most recently wins.
REQ-017 Last-grant pointer SHALL reset to 1, so R0 wins the first tie, and SHALL update to the granted requester on every grant.
REQ-018 Rn_Ready SHALL equal grant n; a transfer is the cycle with Rn_Valid&Rn_Ready; at most one grant per cycle.
REQ-019 Requesters SHALL NOT make Rn_Valid depend on Rn_Ready; Rn_Valid held high with unchanged fields until accepted.
REQ-020 On a granted cycle, outputs SHALL be Csb0=0, Web0=~Rn_We, ADDR0=Rn_Addr, DIN0=Rn_Wdata; with no grant in RUN, Csb0=1, Web0=1, ADDR0=0, DIN0=0.
REQ-021 A granted read (We=0) SHALL assert Rn_RspValid for exactly one cycle, the cycle immediately after the transfer; latency is 1.
REQ-022 Rn_RspData SHALL equal DOUT0 continuously; it is meaningful only while Rn_RspValid=1.
REQ-023 Granted writes SHALL produce no response.
REQ-024 Back-to-back transfers SHALL be sustained at one per cycle, including alternating readers, each response tagged to its own requester.
REQ-025 A read of an address written in the previous cycle SHALL return the new data.
REQ-026 R0_RspValid and R1_RspValid SHALL never be high in the same cycle.

Reset
REQ-027 Rst_n low SHALL immediately set state=BOOT, init counter=0, Init_Done=0, both RspValid=0 and last-grant=1.
REQ-028 While Rst_n is low, Csb0=1 and Web0=1, so no RAM access occurs.
REQ-029 Reset mid-INIT or mid-RUN SHALL drop any pending read response and restart the full clear sequence after release.

Verification
REQ-030 Init, AW=4: release reset -> 1 BOOT cycle; 16 write cycles to addresses 0..15 with DIN0=0; Init_Done=1 on the 18th cycle after release; Ready=0 throughout.
REQ-031 Single read, AW=4: R0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> R0_RspValid=1 one cycle after the read transfer, R0_RspData=0xDEADBEEF; R1_RspValid stays 0.
REQ-032 Tie: R0 and R1 both hold Valid for 4 cycles -> grants R0,R1,R0,R1; every RAM cycle has Csb0=0.
REQ-033 Interleave: R0 reads addr 3 (0x11), next cycle R1 reads addr 7 (0x22) -> consecutive responses R0=0x11 then R1=0x22, never overlapping.
REQ-034 Reset mid-RUN: assert Rst_n low the cycle after a read transfer -> RspValid stays 0, Csb0=1 while low, full 16-cycle clear repeats after release, and a later read of addr 5 returns 0.
REQ-035 Idle RUN: no Valid for 10 cycles -> Csb0=1, Web0=1, ADDR0=0, both Ready=0 every cycle.
